// File: rtl/exec_wb_stage.sv
// -----------------------------------------------------------------------------
// exec_wb_stage
//
// Execute / write-back stage. Accepts one ALU operation per cycle, computes the
// result and presents it on a registered write-back port that drives the
// register bank write side. MUL is a multi-cycle shift-add operation; the stage
// is not ready for new work while a multiply is in flight.
//
// Parameters
//   DIR_WIDTH   register address width
//   DATA_WIDTH  operand / result width
//
// Ports
//   clk         single clock, rising-edge active
//   arst_n      asynchronous active-low reset
//   in_valid    operation request valid
//   in_ready    stage can accept an operation this cycle
//   op          opcode
//   rd_dir      destination register address
//   rs1_data    first operand
//   rs2_data    second operand
//   wb_en       write-back enable (one cycle per completed op, never for rd 0)
//   wb_dir      write-back register address (holds while wb_en is low)
//   wb_data     write-back data (holds while wb_en is low)
//   busy        multiply in progress
//   illegal_op  one-cycle pulse for an accepted undefined opcode
//
// FSM states
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | ready; single-cycle ops complete straight into write-back
//   ST_MUL  | shift-add multiply running, one iteration per clock
// -----------------------------------------------------------------------------
module exec_wb_stage #(
  parameter int DIR_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [DIR_WIDTH-1:0]  rd_dir,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  wb_en,
  output logic [DIR_WIDTH-1:0]  wb_dir,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  busy,
  output logic                  illegal_op
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DIR_WIDTH-1:0]  r_mul_dir;
  logic                  r_wb_en;
  logic [DIR_WIDTH-1:0]  r_wb_dir;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic                  r_illegal;

  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_is_mul;
  logic                  w_is_illegal;
  logic [4:0]            w_shamt;
  logic [DATA_WIDTH-1:0] w_acc_next;
  logic                  w_accept;

  assign w_shamt  = rs2_data[4:0];
  assign w_accept = in_valid && (r_state == ST_IDLE);

  // One shift-add step: add the (pre-shifted) multiplicand when the current
  // multiplier LSB is set. Only the low DATA_WIDTH bits are kept.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_res        = '0;
    w_is_mul     = 1'b0;
    w_is_illegal = 1'b0;
    case (op)
      OP_ADD:  w_res = rs1_data + rs2_data;
      OP_SUB:  w_res = rs1_data - rs2_data;
      OP_AND:  w_res = rs1_data & rs2_data;
      OP_OR:   w_res = rs1_data | rs2_data;
      OP_XOR:  w_res = rs1_data ^ rs2_data;
      OP_SLT:  w_res = DATA_WIDTH'($signed(rs1_data) < $signed(rs2_data));
      OP_SLTU: w_res = DATA_WIDTH'(rs1_data < rs2_data);
      OP_SLL:  w_res = rs1_data << w_shamt;
      OP_SRL:  w_res = rs1_data >> w_shamt;
      OP_SRA:  w_res = DATA_WIDTH'($signed(rs1_data) >>> w_shamt);
      OP_MUL:  w_is_mul = 1'b1;
      OP_PASS: w_res = rs2_data;
      default: w_is_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_mul_dir <= '0;
      r_wb_en   <= 1'b0;
      r_wb_dir  <= '0;
      r_wb_data <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_wb_en   <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state   <= ST_MUL;
              r_cnt     <= '0;
              r_acc     <= '0;
              r_mcand   <= rs1_data;
              r_mplier  <= rs2_data;
              r_mul_dir <= rd_dir;
            end else if (w_is_illegal) begin
              r_illegal <= 1'b1;
            end else begin
              // Register 0 is hardwired; the address/data still move so the
              // port always reflects the most recent completed op.
              r_wb_en   <= (rd_dir != '0);
              r_wb_dir  <= rd_dir;
              r_wb_data <= w_res;
            end
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == CNT_LAST) begin
            // Last iteration: the final sum goes straight to the port so the
            // result appears in the same cycle the stage becomes ready.
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_wb_en   <= (r_mul_dir != '0);
            r_wb_dir  <= r_mul_dir;
            r_wb_data <= w_acc_next;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_MUL);
  assign wb_en      = r_wb_en;
  assign wb_dir     = r_wb_dir;
  assign wb_data    = r_wb_data;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Bench for exec_wb_stage: directed vectors, a result/timing model computed
// from plain arithmetic, a per-cycle compare against that model, and literal
// checks on the documented example values.
module tb_exec_wb_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = 4'd0;
  logic [AW-1:0] rd_dir = '0;
  logic [DW-1:0] rs1_data = '0;
  logic [DW-1:0] rs2_data = '0;
  logic          wb_en;
  logic [AW-1:0] wb_dir;
  logic [DW-1:0] wb_data;
  logic          busy;
  logic          illegal_op;

  int total = 0;
  int bad   = 0;

  exec_wb_stage #(.DIR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd_dir(rd_dir), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_dir(wb_dir), .wb_data(wb_data), .busy(busy),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_alu(input logic [3:0] o, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    case (o)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6:  r = (a < b) ? 1 : 0;
      4'd7:  r = a << b[4:0];
      4'd8:  r = a >> b[4:0];
      4'd9:  r = DW'($signed(a) >>> b[4:0]);
      4'd10: r = a * b;
      4'd11: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic          m_wb_en = 0;
  logic [AW-1:0] m_wb_dir = '0;
  logic [DW-1:0] m_wb_data = '0;
  logic          m_ill = 0;
  int            m_left = 0;   // clocks until the pending multiply completes
  logic [DW-1:0] m_prod = '0;
  logic [AW-1:0] m_pdir = '0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_wb_en = 0; m_wb_dir = '0; m_wb_data = '0; m_ill = 0; m_left = 0;
    end else begin
      m_wb_en = 0;
      m_ill   = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_wb_en   = (m_pdir != 0);
          m_wb_dir  = m_pdir;
          m_wb_data = m_prod;
        end
      end else if (in_valid) begin
        if (op == 4'd10) begin
          m_left = DW;
          m_prod = ref_alu(op, rs1_data, rs2_data);
          m_pdir = rd_dir;
        end else if (op > 4'd11) begin
          m_ill = 1;
        end else begin
          m_wb_en   = (rd_dir != 0);
          m_wb_dir  = rd_dir;
          m_wb_data = ref_alu(op, rs1_data, rs2_data);
        end
      end
    end
  end

  // Per-cycle compare, mid-cycle away from the active edge.
  always @(negedge clk) begin
    chk("wb_en",      DW'(wb_en),      DW'(m_wb_en));
    chk("wb_dir",     DW'(wb_dir),     DW'(m_wb_dir));
    chk("wb_data",    wb_data,         m_wb_data);
    chk("illegal_op", DW'(illegal_op), DW'(m_ill));
    chk("busy",       DW'(busy),       DW'(m_left != 0));
    chk("in_ready",   DW'(in_ready),   DW'(m_left == 0));
  end

  // ---------------- stimulus ----------------
  // Presents a request at a falling edge and holds it until the stage is ready;
  // on return the request will be taken at the next rising edge.
  task automatic send(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [AW-1:0] rd, output int waited);
    @(negedge clk);
    op = o; rs1_data = a; rs2_data = b; rd_dir = rd; in_valid = 1'b1;
    waited = 0;
    while (!in_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 100) begin
        chk("ready_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic drop();
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'd0; rs1_data = '0; rs2_data = '0; rd_dir = '0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        chk("busy_timeout", 1, 0);
        break;
      end
    end
  endtask

  // Single op, then check the write-back literal in the following cycle.
  task automatic one(input string nm, input logic [3:0] o, input logic [DW-1:0] a,
                     input logic [DW-1:0] b, input logic [DW-1:0] exp);
    int w;
    send(o, a, b, 5'd1, w);
    drop();
    chk(nm, wb_data, exp);
    chk({nm, "_en"}, DW'(wb_en), 1);
  endtask

  initial begin
    int w;
    int cnt;
    // reset values
    #2;
    chk("rst_wb_en", DW'(wb_en), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_ready", DW'(in_ready), 1);
    chk("rst_busy", DW'(busy), 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    // ADD 5+8 -> rd3
    send(4'd0, 5, 8, 5'd3, w);
    drop();
    chk("add_en", DW'(wb_en), 1);
    chk("add_dir", DW'(wb_dir), 3);
    chk("add_data", wb_data, 13);
    @(negedge clk);
    chk("add_en_off", DW'(wb_en), 0);
    chk("add_hold", wb_data, 13);

    // Fibonacci, back-to-back
    send(4'd0, 1, 1, 5'd4, w);
    send(4'd0, 1, 2, 5'd5, w);
    chk("fib0", wb_data, 2);
    chk("fib0_dir", DW'(wb_dir), 4);
    send(4'd0, 2, 3, 5'd6, w);
    chk("fib1", wb_data, 3);
    chk("fib_ready", DW'(in_ready), 1);
    drop();
    chk("fib2", wb_data, 5);
    chk("fib2_en", DW'(wb_en), 1);

    // arithmetic edge cases and other opcodes
    one("sub", 4'd1, 0, 1, 32'hFFFF_FFFF);
    one("slt", 4'd5, 32'hFFFF_FFFF, 1, 1);
    one("sltu", 4'd6, 32'hFFFF_FFFF, 1, 0);
    one("sra", 4'd9, 32'h8000_0000, 31, 32'hFFFF_FFFF);
    one("add_wrap", 4'd0, 32'hFFFF_FFFF, 1, 0);
    one("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    one("or", 4'd3, 32'hF000_0001, 32'h0000_0100, 32'hF000_0101);
    one("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    one("sll", 4'd7, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030);
    one("srl", 4'd8, 32'h8000_0000, 31, 1);
    one("pass", 4'd11, 32'h1111_1111, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // MUL 12345 x 6789 with an ADD held behind it
    send(4'd10, 12345, 6789, 5'd7, w);
    send(4'd0, 3, 4, 5'd9, w);
    chk("mul_busy_cycles", w, 32);
    chk("mul_en", DW'(wb_en), 1);
    chk("mul_dir", DW'(wb_dir), 7);
    chk("mul_data", wb_data, 83810205);
    chk("mul_ready", DW'(in_ready), 1);
    drop();
    chk("after_mul_add", wb_data, 7);
    chk("after_mul_dir", DW'(wb_dir), 9);

    // MUL all-ones squared
    send(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, w);
    drop();
    wait_ready();
    chk("mul_ones", wb_data, 1);
    chk("mul_ones_en", DW'(wb_en), 1);

    // rd = 0 never writes
    send(4'd0, 1, 2, 5'd0, w);
    drop();
    chk("rd0_en", DW'(wb_en), 0);
    chk("rd0_data", wb_data, 3);

    // illegal opcode
    send(4'd15, 9, 9, 5'd5, w);
    drop();
    chk("ill_pulse", DW'(illegal_op), 1);
    chk("ill_en", DW'(wb_en), 0);
    chk("ill_hold", wb_data, 3);
    @(negedge clk);
    chk("ill_off", DW'(illegal_op), 0);

    // reset 10 cycles into a multiply
    send(4'd10, 1000, 1000, 5'd8, w);
    drop();
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", DW'(busy), 1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_wb_dir", DW'(wb_dir), 0);
    chk("arst_wb_data", wb_data, 0);
    chk("arst_busy", DW'(busy), 0);
    chk("arst_ready", DW'(in_ready), 1);
    chk("arst_ill", DW'(illegal_op), 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (wb_en) cnt++;
    end
    chk("no_wb_after_abort", cnt, 0);
    send(4'd0, 20, 22, 5'd3, w);
    drop();
    chk("post_rst_add", wb_data, 42);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_wb_stage.md
EXEC_WB_STAGE -- requirements
Module: exec_wb_stage

Interface
REQ-001 The block SHALL have parameter DIR_WIDTH, default 5, register address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 arst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 op  input  4  opcode (see REQ-013).
REQ-008 rd_dir  input  DIR_WIDTH  destination register address.
REQ-009 rs1_data, rs2_data  input  DATA_WIDTH each  operands, read from the register bank.
REQ-010 wb_en, wb_dir, wb_data  output  1 / DIR_WIDTH / DATA_WIDTH  registered write-back port; drives the bank's write_en / write_dir / write_data.
REQ-011 busy  output  1  high while a multi-cycle multiply is in progress.
REQ-012 illegal_op  output  1  one-cycle pulse for an accepted undefined opcode.

Function
REQ-013 Opcodes SHALL be as follows; all results are DATA_WIDTH bits, wrap-around, no overflow flag:
- 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
- 5 SLT (signed compare, result 1/0); 6 SLTU (unsigned compare).
- 7 SLL, 8 SRL, 9 SRA: shift rs1 by rs2[4:0].
- 10 MUL: low DATA_WIDTH bits of the unsigned product.
- 11 PASS: result = rs2.
- 12-15 illegal.
REQ-014 An operation SHALL be accepted at a rising edge where in_valid && in_ready; operands, op and rd_dir are sampled only at that edge.
REQ-015 The FSM SHALL have two states, IDLE and MUL; in_ready = 1 in IDLE and 0 in MUL; busy = (state == MUL).
REQ-016 Single-cycle op accepted at edge N: wb_en = 1, wb_dir = rd_dir and wb_data = result SHALL all be valid in the cycle after edge N, for exactly one cycle; state stays IDLE; back-to-back accepts every cycle SHALL be supported.
REQ-017 MUL accepted at edge N: state SHALL go to MUL; a shift-add iteration SHALL occur at edges N+1 .. N+DATA_WIDTH (iteration counter 0..DATA_WIDTH-1).
REQ-018 At edge N+DATA_WIDTH the FSM SHALL return to IDLE and assert the MUL write-back for one cycle. in_ready is 1 in that cycle, so a new op can be accepted while the MUL result is on the write-back port.
REQ-019 When rd_dir == 0, wb_en SHALL stay 0; wb_dir/wb_data still update.
REQ-020 An illegal opcode SHALL be consumed in one cycle: illegal_op = 1 for one cycle, wb_en = 0, state IDLE.
REQ-021 wb_dir and wb_data SHALL hold their last values while wb_en = 0.
REQ-022 in_valid while in_ready = 0 SHALL be ignored; the upstream holds the request until accepted.

Reset
REQ-023 While arst_n = 0, and immediately on assertion regardless of clk:
- state = IDLE, iteration counter = 0, multiplier accumulator = 0;
- wb_en = 0, wb_dir = 0, wb_data = 0, illegal_op = 0, busy = 0;
- in_ready = 1.
REQ-024 Reset during MUL SHALL abort the multiply with no write-back; the first accept is possible at the first rising edge after arst_n deasserts.

Verification
REQ-025 ADD rs1=5, rs2=8, rd=3 accepted at edge N -> cycle after N: wb_en=1, wb_dir=3, wb_data=13; next cycle wb_en=0.
REQ-026 Fibonacci chain, three back-to-back ADDs (1+1, 1+2, 2+3 to rd=4,5,6) -> wb_en high three consecutive cycles with data 2, 3, 5; in_ready constant 1.
REQ-027 Arithmetic edge cases:
- SUB 0-1 -> 0xFFFFFFFF.
- SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF.
- ADD 0xFFFFFFFF+1 -> 0.
REQ-028 MUL 12345 x 6789, rd=7, accepted at edge N:
- in_ready=0 and busy=1 for 32 cycles;
- wb_en=1 with wb_data=83810205 in the cycle after edge N+32;
- new ADD accepted in that same cycle -> its write-back one cycle later.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> 1.
REQ-029 Boundary cases:
- ADD with rd=0 -> wb_en stays 0.
- op=15 -> illegal_op pulses one cycle, no write.
- arst_n low 10 cycles into a MUL -> all outputs 0 immediately, in_ready=1, no wb_en after release.
